// File: rtl/ram_rr_arbiter_pkg.sv
// Shared types and constants for the two-port round-robin RAM arbiter.
//   state_e  : arbiter FSM states (CLEAR, RUN)
//   RW_*     : access-type encoding used on the request ports and on the RAM
package ram_rr_arbiter_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/ram_4x8.sv
// Single-port RAM, 2^ADDR_W words of DATA_W bits, registered read.
//   clk, rst : clock, synchronous active-high reset (clears only the read register)
//   en       : access enable for this cycle
//   rw       : 0 = write wdata to addr, 1 = read addr into rdata next cycle
//   addr     : word address
//   wdata    : write data
//   rdata    : registered read data, holds its value between reads
module ram_4x8
  import ram_rr_arbiter_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && rw == RW_READ) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  // Contents are not reset; the arbiter's clear sequence initialises them.
  always_ff @(posedge clk) begin
    if (en && rw == RW_WRITE) mem_q[addr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// After reset the RAM is zero-filled (one word per cycle), then requests are
// granted one per cycle with rotating priority on contention.
//   clk, rst                 : clock, synchronous active-high reset
//   reqX_valid/rw/addr/wdata : request from requester X (rw 0 = write, 1 = read)
//   reqX_ready               : request X accepted this cycle (combinational)
//   rspX_valid               : rsp_rdata carries read data for requester X
//   rsp_rdata                : shared read-data bus, holds between responses
//   init_done                : clear sequence finished, arbiter in RUN
//
// state | meaning
// CLEAR | writing zero to address clr_cnt_q, all requests stalled
// RUN   | arbitrating requests onto the RAM
module ram_rr_arbiter
  import ram_rr_arbiter_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              prio_q, prio_d;     // requester holding priority
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;

  logic              gnt0, gnt1;
  logic              ram_en, ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    prio_d       = prio_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    ram_en       = 1'b0;
    ram_rw       = RW_READ;
    ram_addr     = clr_cnt_q;
    ram_wdata    = '0;
    // Nothing is granted or written while rst is high, whatever the state.
    if (!rst) begin
      case (state_q)
        CLEAR: begin
          ram_en    = 1'b1;
          ram_rw    = RW_WRITE;
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) state_d = RUN;
        end
        RUN: begin
          gnt0 = req0_valid && (!req1_valid || prio_q == 1'b0);
          gnt1 = req1_valid && (!req0_valid || prio_q == 1'b1);
          if (gnt0) begin
            ram_en       = 1'b1;
            ram_rw       = req0_rw;
            ram_addr     = req0_addr;
            ram_wdata    = req0_wdata;
            prio_d       = 1'b1;
            rsp0_valid_d = (req0_rw == RW_READ);
          end else if (gnt1) begin
            ram_en       = 1'b1;
            ram_rw       = req1_rw;
            ram_addr     = req1_addr;
            ram_wdata    = req1_wdata;
            prio_d       = 1'b0;
            rsp1_valid_d = (req1_rw == RW_READ);
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      prio_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      prio_q       <= prio_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  ram_4x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .rw    (ram_rw),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (rsp_rdata)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  // Masking with rst drops a response that would land in a reset cycle.
  assign rsp0_valid = rsp0_valid_q && !rst;
  assign rsp1_valid = rsp1_valid_q && !rst;
  assign init_done  = (state_q == RUN) && !rst;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
module tb_ram_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_rw = 1'b0;
  logic [2:0] req0_addr = '0;
  logic [3:0] req0_wdata = '0;
  logic       req1_valid = 1'b0, req1_rw = 1'b0;
  logic [2:0] req1_addr = '0;
  logic [3:0] req1_wdata = '0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done;
  logic [3:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0] m_mem [8];
  int         m_prio;
  int         pend_who;   // -1: no response due, else requester owed a response
  logic [3:0] pend_data;

  ram_rr_arbiter #(.ADDR_W(3), .DATA_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_rdata(rsp_rdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
    m_prio   = 0;
    pend_who = -1;
  endtask

  // One cycle: entered and left at a negedge.
  task automatic step(input logic v0, input logic r0, input logic [2:0] a0, input logic [3:0] d0,
                      input logic v1, input logic r1, input logic [2:0] a1, input logic [3:0] d1);
    int who;
    chk("rsp0_valid", 32'(rsp0_valid), 32'(pend_who == 0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(pend_who == 1));
    if (pend_who >= 0) chk("rsp_rdata", 32'(rsp_rdata), 32'(pend_data));
    req0_valid = v0; req0_rw = r0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_rw = r1; req1_addr = a1; req1_wdata = d1;
    #1;
    who = -1;
    if (v0 && v1) who = m_prio;
    else if (v0)  who = 0;
    else if (v1)  who = 1;
    chk("ready0", 32'(req0_ready), 32'(who == 0));
    chk("ready1", 32'(req1_ready), 32'(who == 1));
    pend_who = -1;
    if (who >= 0) begin
      logic       rw;
      logic [2:0] a;
      logic [3:0] d;
      rw = (who == 0) ? r0 : r1;
      a  = (who == 0) ? a0 : a1;
      d  = (who == 0) ? d0 : d1;
      if (rw) begin
        pend_who  = who;
        pend_data = m_mem[a];
      end else begin
        m_mem[a] = d;
      end
      m_prio = 1 - who;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 3'd0, 4'd0);
  endtask

  // Asserts rst for one cycle from a negedge, then follows the clear sequence.
  // Request inputs are left as currently driven.
  task automatic do_reset();
    int n;
    rst = 1'b1;
    #1;
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    model_reset();
    n = 1;
    while (!init_done && n < 20) begin
      chk("clear_ready0", 32'(req0_ready), 32'd0);
      chk("clear_ready1", 32'(req1_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("init_latency", 32'(n), 32'd9);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // all words cleared
    for (int a = 0; a < 8; a++) step(1'b1, 1'b1, 3'(a), 4'd0, 1'b0, 1'b0, 3'd0, 4'd0);
    idle();

    // write then read-after-write
    step(1'b1, 1'b0, 3'd3, 4'hA, 1'b0, 1'b0, 3'd0, 4'd0);
    step(1'b1, 1'b1, 3'd3, 4'h0, 1'b0, 1'b0, 3'd0, 4'd0);
    idle();

    // req1 alone three times, then contention
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b1, 3'd3, 4'd0);
    step(1'b1, 1'b1, 3'd3, 4'd0, 1'b1, 1'b1, 3'd3, 4'd0);
    chk("prio_after_contention", 32'(m_prio), 32'd1);
    idle();

    // fill addrs 1/2, then continuous contended reads
    step(1'b1, 1'b0, 3'd1, 4'h5, 1'b0, 1'b0, 3'd0, 4'd0);
    step(1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 3'd2, 4'h9);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'd1, 4'd0, 1'b1, 1'b1, 3'd2, 4'd0);
    idle();

    // random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 1'($urandom), 3'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom), 3'($urandom), 4'($urandom));
    idle();

    // reset the cycle after a read is accepted; hold a request through CLEAR
    step(1'b1, 1'b0, 3'd5, 4'h7, 1'b0, 1'b0, 3'd0, 4'd0);
    step(1'b1, 1'b1, 3'd5, 4'h0, 1'b0, 1'b0, 3'd0, 4'd0);
    req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 3'd0;
    req1_valid = 1'b0;
    do_reset();
    step(1'b1, 1'b1, 3'd0, 4'd0, 1'b0, 1'b0, 3'd0, 4'd0);
    step(1'b1, 1'b1, 3'd5, 4'd0, 1'b0, 1'b0, 3'd0, 4'd0);
    step(1'b1, 1'b1, 3'd3, 4'd0, 1'b0, 1'b0, 3'd0, 4'd0);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
